// File: rtl/ad7124_scan_ctrl.sv
// Lockstep AD7124 scanner: walks NUM_OF_CH chip selects shared by NUM_OF_BOARD boards, reads one
// 32-bit conversion word per board per channel over SPI mode 3 and writes it out on wr_*.
module ad7124_scan_ctrl #(
  parameter int NUM_OF_BOARD = 6,
  parameter int NUM_OF_CH    = 8,
  parameter int SCLK_DIV     = 8,
  parameter int TIMEOUT      = 1048576,
  localparam int ADDR_W      = $clog2(NUM_OF_BOARD*NUM_OF_CH)
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    start,
  input  logic                    continuous,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done_irq,
  output logic [31:0]             scan_count,
  output logic [NUM_OF_BOARD-1:0] timeout_err,
  output logic                    spi_sclk,
  output logic [NUM_OF_CH-1:0]    spi_csn,
  output logic                    spi_sdi,
  input  logic [NUM_OF_BOARD-1:0] spi_sdo,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [31:0]             wr_data
);

  // state    | meaning
  // IDLE     | waiting for start
  // CS_SETUP | CSN low, SCLK_DIV cycles before RDY is looked at
  // WAIT_RDY | waiting for every DOUT/RDY low, bounded by TIMEOUT
  // SHIFT    | 40 SCLK periods: 8 command bits out, 32 data bits in
  // CS_HOLD  | SCLK high for SCLK_DIV cycles, then CSN released
  // WRITE    | one result word per board
  // NEXT     | advance channel, finish or restart the scan
  localparam int         CH_W     = (NUM_OF_CH > 1) ? $clog2(NUM_OF_CH) : 1;
  localparam int         BRD_W    = (NUM_OF_BOARD > 1) ? $clog2(NUM_OF_BOARD) : 1;
  localparam int         DIV_W    = $clog2(SCLK_DIV);
  localparam int         TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [7:0] CMD      = 8'h42;
  localparam logic [5:0] LAST_BIT = 6'd39;
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(SCLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, CS_SETUP, WAIT_RDY, SHIFT, CS_HOLD, WRITE, NEXT
  } state_t;

  state_t                  state_q, state_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [BRD_W-1:0]        wb_q, wb_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic [5:0]              bit_q, bit_d;
  logic [7:0]              cmd_q, cmd_d;
  logic [31:0]             shreg_q [NUM_OF_BOARD];
  logic [31:0]             shreg_d [NUM_OF_BOARD];
  logic [NUM_OF_BOARD-1:0] bad_q, bad_d;
  logic                    abort_q, abort_d;
  logic                    sclk_q, sclk_d;
  logic [NUM_OF_CH-1:0]    csn_q, csn_d;
  logic                    sdi_q, sdi_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [31:0]             scan_q, scan_d;
  logic [NUM_OF_BOARD-1:0] tmo_err_q, tmo_err_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
  logic [31:0]             wr_data_q, wr_data_d;

  function automatic logic [NUM_OF_CH-1:0] csn_for(input logic [CH_W-1:0] c);
    return ~(NUM_OF_CH'(1) << c);
  endfunction

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    wb_d      = wb_q;
    div_d     = div_q;
    tmo_d     = tmo_q;
    bit_d     = bit_q;
    cmd_d     = cmd_q;
    shreg_d   = shreg_q;
    bad_d     = bad_q;
    abort_d   = abort_q;
    sclk_d    = sclk_q;
    csn_d     = csn_q;
    sdi_d     = sdi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    scan_d    = scan_q;
    tmo_err_d = tmo_err_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d   = CS_SETUP;
          ch_d      = '0;
          csn_d     = csn_for('0);
          div_d     = DIV_RELOAD;
          busy_d    = 1'b1;
          tmo_err_d = '0;
          abort_d   = 1'b0;
        end
      end

      CS_SETUP, WAIT_RDY, SHIFT: begin
        if (abort) begin
          state_d = CS_HOLD;
          sclk_d  = 1'b1;
          sdi_d   = 1'b0;
          div_d   = DIV_RELOAD;
          abort_d = 1'b1;
        end else if (state_q == CS_SETUP) begin
          if (div_q != '0) begin
            div_d = div_q - 1'b1;
          end else begin
            state_d = WAIT_RDY;
            tmo_d   = TMO_W'(TIMEOUT - 1);
          end
        end else if (state_q == WAIT_RDY) begin
          if (spi_sdo == '0 || tmo_q == '0) begin
            // boards still showing RDY high at timeout are flagged and their word discarded
            bad_d     = spi_sdo;
            tmo_err_d = tmo_err_q | spi_sdo;
            state_d   = SHIFT;
            sclk_d    = 1'b0;
            sdi_d     = CMD[7];
            cmd_d     = {CMD[6:0], 1'b0};
            bit_d     = '0;
            div_d     = DIV_RELOAD;
          end else begin
            tmo_d = tmo_q - 1'b1;
          end
        end else begin
          if (div_q != '0) begin
            div_d = div_q - 1'b1;
          end else if (!sclk_q) begin
            sclk_d = 1'b1;
            div_d  = DIV_RELOAD;
            for (int b = 0; b < NUM_OF_BOARD; b++) begin
              shreg_d[b] = {shreg_q[b][30:0], spi_sdo[b]};
            end
          end else if (bit_q == LAST_BIT) begin
            state_d = CS_HOLD;
            sdi_d   = 1'b0;
            div_d   = DIV_RELOAD;
          end else begin
            bit_d  = bit_q + 6'd1;
            sclk_d = 1'b0;
            sdi_d  = cmd_q[7];
            cmd_d  = {cmd_q[6:0], 1'b0};
            div_d  = DIV_RELOAD;
          end
        end
      end

      CS_HOLD: begin
        abort_d = abort_q | abort;
        if (div_q != '0) begin
          div_d = div_q - 1'b1;
        end else begin
          csn_d = '1;
          if (abort_q || abort) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = WRITE;
            wb_d    = '0;
          end
        end
      end

      WRITE: begin
        abort_d   = abort_q | abort;
        wr_en_d   = 1'b1;
        wr_addr_d = ADDR_W'(32'(ch_q) * NUM_OF_BOARD + 32'(wb_q));
        wr_data_d = bad_q[wb_q] ? 32'hFFFF_FFFF : shreg_q[wb_q];
        if (wb_q == BRD_W'(NUM_OF_BOARD - 1)) begin
          state_d = NEXT;
        end else begin
          wb_d = wb_q + 1'b1;
        end
      end

      NEXT: begin
        if (abort_q || abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (ch_q != CH_W'(NUM_OF_CH - 1)) begin
          ch_d    = ch_q + 1'b1;
          csn_d   = csn_for(ch_q + 1'b1);
          div_d   = DIV_RELOAD;
          state_d = CS_SETUP;
        end else begin
          done_d = 1'b1;
          scan_d = scan_q + 32'd1;
          if (continuous) begin
            ch_d    = '0;
            csn_d   = csn_for('0);
            div_d   = DIV_RELOAD;
            state_d = CS_SETUP;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      wb_q      <= '0;
      div_q     <= '0;
      tmo_q     <= '0;
      bit_q     <= '0;
      cmd_q     <= '0;
      shreg_q   <= '{default: '0};
      bad_q     <= '0;
      abort_q   <= 1'b0;
      sclk_q    <= 1'b1;
      csn_q     <= '1;
      sdi_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      scan_q    <= '0;
      tmo_err_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      wb_q      <= wb_d;
      div_q     <= div_d;
      tmo_q     <= tmo_d;
      bit_q     <= bit_d;
      cmd_q     <= cmd_d;
      shreg_q   <= shreg_d;
      bad_q     <= bad_d;
      abort_q   <= abort_d;
      sclk_q    <= sclk_d;
      csn_q     <= csn_d;
      sdi_q     <= sdi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      scan_q    <= scan_d;
      tmo_err_q <= tmo_err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign busy        = busy_q;
  assign done_irq    = done_q;
  assign scan_count  = scan_q;
  assign timeout_err = tmo_err_q;
  assign spi_sclk    = sclk_q;
  assign spi_csn     = csn_q;
  assign spi_sdi     = sdi_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;

endmodule

// File: tb/tb_ad7124_scan_ctrl.sv
// Bench for ad7124_scan_ctrl: behavioural AD7124 boards on the SPI side, expected result writes
// built from per-channel word tables.
module tb_ad7124_scan_ctrl;
  localparam int NB  = 6;
  localparam int NCH = 8;
  localparam int SD  = 2;
  localparam int TMO = 100;
  localparam int AW  = 6;

  logic aclk = 1'b0, areset = 1'b1, start = 1'b0, continuous = 1'b0, abort = 1'b0;
  logic busy, done_irq, spi_sclk, spi_sdi, wr_en;
  logic [31:0] scan_count, wr_data;
  logic [NB-1:0] timeout_err, spi_sdo;
  logic [NCH-1:0] spi_csn;
  logic [AW-1:0] wr_addr;

  always #5 aclk = ~aclk;

  ad7124_scan_ctrl #(.NUM_OF_BOARD(NB), .NUM_OF_CH(NCH), .SCLK_DIV(SD), .TIMEOUT(TMO)) dut (
    .aclk(aclk), .areset(areset), .start(start), .continuous(continuous), .abort(abort),
    .busy(busy), .done_irq(done_irq), .scan_count(scan_count), .timeout_err(timeout_err),
    .spi_sclk(spi_sclk), .spi_csn(spi_csn), .spi_sdi(spi_sdi), .spi_sdo(spi_sdo),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

  int n_total = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- ADC boards ----------------
  logic [31:0] adc_word [NCH][NB];
  logic [NB-1:0] stuck = '0, sdo_r = '1;
  int rdy_min = 3, rdy_max = 20;
  int k = 0, rdy_cnt = 0, cur_ch = 0, cyc = 0, last_fall = 0;
  int frame_falls = 0, per_min = 1000, per_max = 0;
  int sdi_bad = 0, rd_sdi_bad = 0, csn_multi_bad = 0;
  bit cs_active = 0;
  logic sclk_prev = 1'b1, sdi_prev = 1'b0;
  logic [7:0] cmd_sh = '0, last_cmd = '0;
  assign spi_sdo = sdo_r;

  always @(negedge aclk) begin
    cyc++;
    if ((spi_sdi !== sdi_prev) && !(sclk_prev && !spi_sclk)) sdi_bad++;
    if (spi_csn === '1) begin
      if (cs_active) begin
        last_cmd    = cmd_sh;
        frame_falls = k;
        cs_active   = 0;
      end
      sdo_r = '1;
      k     = 0;
    end else begin
      if ($countones(~spi_csn) != 1) csn_multi_bad++;
      if (!cs_active) begin
        cs_active = 1;
        k         = 0;
        cmd_sh    = '0;
        sdo_r     = '1;
        rdy_cnt   = $urandom_range(rdy_max, rdy_min);
        for (int c = 0; c < NCH; c++) if (!spi_csn[c]) cur_ch = c;
      end
      if (k == 0) begin
        if (rdy_cnt > 0) rdy_cnt--;
        else sdo_r = stuck;
      end
      if (sclk_prev && !spi_sclk) begin
        if (k > 0) begin
          if (cyc - last_fall < per_min) per_min = cyc - last_fall;
          if (cyc - last_fall > per_max) per_max = cyc - last_fall;
        end
        last_fall = cyc;
        k++;
        if (k >= 9 && k <= 40)
          for (int b = 0; b < NB; b++) sdo_r[b] = stuck[b] | adc_word[cur_ch][b][40-k];
      end
      if (!sclk_prev && spi_sclk) begin
        if (k >= 1 && k <= 8) cmd_sh = {cmd_sh[6:0], spi_sdi};
        else if (k > 8 && spi_sdi !== 1'b0) rd_sdi_bad++;
      end
    end
    sclk_prev = spi_sclk;
    sdi_prev  = spi_sdi;
  end

  // ---------------- write / irq capture ----------------
  logic [AW-1:0] got_addr[$], exp_addr[$];
  logic [31:0]   got_data[$], exp_data[$];
  int done_cycles = 0;

  always @(negedge aclk) begin
    if (wr_en === 1'b1) begin
      got_addr.push_back(wr_addr);
      got_data.push_back(wr_data);
    end
    if (done_irq === 1'b1) done_cycles++;
  end

  task automatic expect_scan(input int nch);
    for (int c = 0; c < nch; c++)
      for (int b = 0; b < NB; b++) begin
        exp_addr.push_back(AW'(c * NB + b));
        exp_data.push_back(stuck[b] ? 32'hFFFF_FFFF : adc_word[c][b]);
      end
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check({tag, "_nwr"}, 64'(got_addr.size()), 64'(exp_addr.size()));
    n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr%0d", tag, i), 64'(got_addr[i]), 64'(exp_addr[i]));
      check($sformatf("%s_data%0d", tag, i), 64'(got_data[i]), 64'(exp_data[i]));
    end
    got_addr.delete(); got_data.delete(); exp_addr.delete(); exp_data.delete();
  endtask

  task automatic rand_words();
    for (int c = 0; c < NCH; c++)
      for (int b = 0; b < NB; b++) adc_word[c][b] = $urandom;
  endtask

  task automatic pulse_start();
    @(negedge aclk) start = 1'b1;
    @(negedge aclk) start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int lim);
    int n = 0;
    while (busy === 1'b1 && n < lim) begin
      @(negedge aclk);
      n++;
    end
    check({tag, "_idle"}, 64'(busy), 64'd0);
    repeat (3) @(negedge aclk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_sclk"}, 64'(spi_sclk), 64'd1);
    check({tag, "_csn"}, 64'(spi_csn), 64'(8'hFF));
    check({tag, "_sdi"}, 64'(spi_sdi), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done_irq), 64'd0);
    check({tag, "_wren"}, 64'(wr_en), 64'd0);
    check({tag, "_waddr"}, 64'(wr_addr), 64'd0);
    check({tag, "_wdata"}, 64'(wr_data), 64'd0);
    check({tag, "_cnt"}, 64'(scan_count), 64'd0);
    check({tag, "_terr"}, 64'(timeout_err), 64'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge aclk);
    check_reset("rst");
    areset = 1'b0;
    @(negedge aclk);

    // plain scan, fixed conversion word, SCLK timing and command byte
    for (int c = 0; c < NCH; c++) for (int b = 0; b < NB; b++) adc_word[c][b] = 32'h1234_5605;
    sdi_bad = 0; rd_sdi_bad = 0; csn_multi_bad = 0; per_min = 1000; per_max = 0; done_cycles = 0;
    pulse_start();
    check("a_busy_on", 64'(busy), 64'd1);
    wait_idle("a", 10000);
    expect_scan(NCH);
    compare_writes("a");
    check("a_done", 64'(done_cycles), 64'd1);
    check("a_cnt", 64'(scan_count), 64'd1);
    check("a_terr", 64'(timeout_err), 64'd0);
    check("a_cmd", 64'(last_cmd), 64'h42);
    check("a_falls", 64'(frame_falls), 64'd40);
    check("a_per_min", 64'(per_min), 64'(2 * SD));
    check("a_per_max", 64'(per_max), 64'(2 * SD));
    check("a_sdi_edge", 64'(sdi_bad), 64'd0);
    check("a_sdi_read", 64'(rd_sdi_bad), 64'd0);
    check("a_csn_onehot", 64'(csn_multi_bad), 64'd0);

    // board 3 never shows RDY
    rand_words();
    stuck = 6'b001000; done_cycles = 0;
    pulse_start();
    wait_idle("b", 20000);
    expect_scan(NCH);
    compare_writes("b");
    check("b_terr", 64'(timeout_err), 64'h08);
    check("b_cnt", 64'(scan_count), 64'd2);
    check("b_done", 64'(done_cycles), 64'd1);

    // continuous for three scans
    stuck = '0;
    rand_words();
    done_cycles = 0; continuous = 1'b1;
    pulse_start();
    check("c_terr_clr", 64'(timeout_err), 64'd0);
    n = 0;
    while (done_cycles < 2 && n < 30000) begin
      @(negedge aclk);
      n++;
    end
    check("c_two_done", 64'(done_cycles), 64'd2);
    continuous = 1'b0;
    wait_idle("c", 10000);
    expect_scan(NCH); expect_scan(NCH); expect_scan(NCH);
    compare_writes("c");
    check("c_done", 64'(done_cycles), 64'd3);
    check("c_cnt", 64'(scan_count), 64'd5);

    // abort during SHIFT of channel 2
    rand_words();
    done_cycles = 0;
    pulse_start();
    n = 0;
    while (!(cs_active && cur_ch == 2 && k >= 12) && n < 10000) begin
      @(negedge aclk);
      n++;
    end
    check("d_reach_ch2", 64'(cur_ch), 64'd2);
    @(negedge aclk) abort = 1'b1;
    @(negedge aclk) abort = 1'b0;
    n = 0;
    while (spi_csn !== '1 && n < 50) begin
      @(negedge aclk);
      n++;
    end
    check("d_csn_lat", 64'(n), 64'(SD));
    check("d_busy", 64'(busy), 64'd0);
    wait_idle("d", 100);
    expect_scan(2);
    compare_writes("d");
    check("d_done", 64'(done_cycles), 64'd0);
    check("d_cnt", 64'(scan_count), 64'd5);

    // abort during WRITE of channel 0
    rand_words();
    done_cycles = 0;
    pulse_start();
    n = 0;
    while (wr_en !== 1'b1 && n < 10000) begin
      @(negedge aclk);
      n++;
    end
    check("e_wr_seen", 64'(wr_en), 64'd1);
    abort = 1'b1;
    @(negedge aclk) abort = 1'b0;
    wait_idle("e", 100);
    expect_scan(1);
    compare_writes("e");
    check("e_done", 64'(done_cycles), 64'd0);
    check("e_cnt", 64'(scan_count), 64'd5);

    // start and abort together while idle
    @(negedge aclk) begin start = 1'b1; abort = 1'b1; end
    @(negedge aclk) begin start = 1'b0; abort = 1'b0; end
    check("f_busy", 64'(busy), 64'd0);
    check("f_csn", 64'(spi_csn), 64'(8'hFF));
    repeat (4) @(negedge aclk);
    check("f_busy_later", 64'(busy), 64'd0);

    // reset while waiting for RDY, then a normal scan
    rdy_min = 60; rdy_max = 60;
    pulse_start();
    n = 0;
    while (spi_csn === '1 && n < 100) begin
      @(negedge aclk);
      n++;
    end
    repeat (SD + 5) @(negedge aclk);
    areset = 1'b1;
    @(negedge aclk);
    check_reset("g_rst");
    areset = 1'b0;
    rdy_min = 3; rdy_max = 20;
    repeat (3) @(negedge aclk);
    check("g_no_wr", 64'(got_addr.size()), 64'd0);
    got_addr.delete(); got_data.delete();
    rand_words();
    done_cycles = 0;
    pulse_start();
    wait_idle("g", 10000);
    expect_scan(NCH);
    compare_writes("g");
    check("g_cnt", 64'(scan_count), 64'd1);
    check("g_done", 64'(done_cycles), 64'd1);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule

// File: doc/ad7124_scan_ctrl.md
AD7124_SCAN_CTRL -- requirements
Module: ad7124_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_OF_BOARD, default 6, number of AD boards scanned in lockstep.
REQ-002 SHALL have parameter NUM_OF_CH, default 8, number of chip selects per board.
REQ-003 SHALL have parameter SCLK_DIV, default 8, aclk cycles per SCLK half-period, legal range >=2.
REQ-004 SHALL have parameter TIMEOUT, default 1048576, aclk cycles allowed for RDY per channel.
REQ-005 SHALL define local ADDR_W = clog2(NUM_OF_BOARD*NUM_OF_CH).
REQ-006 SHALL run from one clock and use a synchronous, active-high reset.
REQ-007 aclk  in  1  sole clock.
REQ-008 areset  in  1  synchronous active-high reset.
REQ-009 start  in  1  one-cycle request to begin a scan; ignored while busy.
REQ-010 continuous  in  1  restart the scan automatically after each completed scan.
REQ-011 abort  in  1  terminate the current scan.
REQ-012 busy  out  1  high from the start accept until return to IDLE.
REQ-013 done_irq  out  1  one-cycle pulse per completed scan.
REQ-014 scan_count  out  32  number of completed scans, wraps at 2^32.
REQ-015 timeout_err  out  NUM_OF_BOARD  sticky per-board RDY-timeout flags, cleared on start accept.
REQ-016 spi_sclk  out  1  shared SCLK, SPI mode 3.
REQ-017 spi_csn  out  NUM_OF_CH  active-low chip selects, shared by all boards.
REQ-018 spi_sdi  out  1  command line to the ADCs.
REQ-019 spi_sdo  in  NUM_OF_BOARD  per-board DOUT/RDY.
REQ-020 wr_en / wr_addr / wr_data  out  1 / ADDR_W / 32  result write port.

Function
REQ-021 SHALL implement states IDLE, CS_SETUP, WAIT_RDY, SHIFT, CS_HOLD, WRITE and NEXT.
REQ-022 IDLE->CS_SETUP on start; set ch=0 and assert spi_csn[ch] low; all other CSN bits stay high.
REQ-023 CS_SETUP SHALL last SCLK_DIV cycles, then go to WAIT_RDY.
REQ-024 WAIT_RDY SHALL exit when all spi_sdo bits are low, or when TIMEOUT cycles have elapsed.
REQ-025 On a WAIT_RDY timeout, every board with spi_sdo still high SHALL set its timeout_err bit and be marked bad for this channel.
REQ-026 SHIFT SHALL clock 40 SCLK periods: 8 command bits, then 32 read bits.
REQ-027 Command bits SHALL be 0x42 on spi_sdi, MSB first; spi_sdi SHALL be 0 during the read phase.
REQ-028 spi_sdi SHALL change on SCLK falling edges; spi_sdo SHALL be sampled on SCLK rising edges, MSB first, into per-board 32-bit registers.
REQ-029 CS_HOLD SHALL last SCLK_DIV cycles with SCLK high, then raise CSN.
REQ-030 WRITE SHALL issue NUM_OF_BOARD consecutive wr_en cycles, board b=0 first.
REQ-031 Each WRITE cycle SHALL use wr_addr = ch*NUM_OF_BOARD + b.
REQ-032 Each WRITE cycle SHALL use wr_data = the received word (data[31:8], status[7:0]), or 0xFFFFFFFF if board b was marked bad.
REQ-033 NEXT: if ch < NUM_OF_CH-1, increment ch and go to CS_SETUP.
REQ-034 NEXT on the last channel: pulse done_irq and increment scan_count, then go to CS_SETUP with ch=0 if continuous=1, else to IDLE.
REQ-035 abort in CS_SETUP, WAIT_RDY or SHIFT SHALL go to CS_HOLD and then IDLE, skip WRITE, with no done_irq and no scan_count change.
REQ-036 abort in WRITE or NEXT SHALL finish the current channel's writes, then go to IDLE with no done_irq.
REQ-037 Simultaneous start and abort while IDLE: abort wins and the block stays IDLE.

Reset
REQ-038 During and after areset the outputs SHALL be:
- spi_sclk=1, spi_csn all 1, spi_sdi=0;
- busy=0, done_irq=0, wr_en=0, wr_addr=0, wr_data=0;
- scan_count=0, timeout_err=0;
- state=IDLE.
REQ-039 areset mid-scan SHALL take effect on the next aclk edge with no further writes.

Verification
REQ-040 Defaults; ADC model returns 0x123456 data and 0x05 status; start -> 48 writes: addr 0..47, data 0x12345605, one done_irq, scan_count=1.
REQ-041 Board 3 holds spi_sdo high; TIMEOUT=100 -> timeout_err=0x08; addrs 3,9,...,45 get 0xFFFFFFFF; other boards' data is intact.
REQ-042 continuous=1 for 3 scans, then cleared -> 3 done_irq pulses, scan_count=3, then IDLE.
REQ-043 abort during SHIFT of ch 2 -> CSN high after SCLK_DIV cycles; no writes with addr >= 12; busy drops; no done_irq.
REQ-044 SCLK_DIV=2 -> SCLK period 4 aclk cycles; spi_sdi shows 0x42 MSB first, changing only on falling edges.
REQ-045 areset asserted in WAIT_RDY -> next cycle all outputs at reset values; a following start scans normally.
